hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Control-side driver for the pipeline registers.
- Detects load-use hazards between ID and EX, and taken branches resolved in MEM.
- Drives PC write-enable, IF/ID write-enable, and the flush inputs of IF/ID, ID/EX and EX/MEM.
- Carries a small state machine, saturating performance counters and a stall watchdog that flags a stuck pipeline.

Parameters:
- CNT_W, 16, width of stall_count and flush_count.
- MAX_STALL, 2, consecutive stall cycles that set hazard_error; legal range 2..15.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  reset, synchronous, active-high.
- ifid_rs  in  5  rs field of the instruction in IF/ID.
- ifid_rt  in  5  rt field of the instruction in IF/ID.
- ifid_uses_rt  in  1  instruction in IF/ID reads rt (R-type, store, branch).
- idex_memread  in  1  memread control currently held in ID/EX.
- idex_rt  in  5  rt destination currently held in ID/EX.
- branch_taken  in  1  branch in EX/MEM resolved taken (branch AND zero).
- pc_write  out  1  PC load enable.
- ifid_write  out  1  IF/ID load enable.
- ifid_flush  out  1  zero IF/ID on next edge.
- idex_flush  out  1  zero ID/EX on next edge (bubble).
- exmem_flush  out  1  zero EX/MEM on next edge.
- stall_count  out  CNT_W  number of load-use stall cycles since reset.
- flush_count  out  CNT_W  number of branch flush events since reset.
- hazard_error  out  1  sticky watchdog flag.
- state_o  out  2  current FSM state.

Behaviour:
- Hazard detection (combinational, same cycle):
  - lu = idex_memread AND idex_rt != 0 AND (idex_rt == ifid_rs OR (ifid_uses_rt AND idex_rt == ifid_rt)).
  - br = branch_taken.
- Controls are combinational from the current inputs, so the pipeline registers act on the same edge. Priority is br > lu > none.
  - br: pc_write=1 (PC loads the branch target), ifid_write=1, ifid_flush=1, idex_flush=1, exmem_flush=1.
  - lu and not br: pc_write=0, ifid_write=0, idex_flush=1, ifid_flush=0, exmem_flush=0.
  - none: pc_write=1, ifid_write=1, all flushes 0.
- While reset is high: pc_write=0, ifid_write=0, all three flushes 1, independent of other inputs.
- FSM (registered), encoding RUN=0, STALL=1, FLUSH=2.
  - Next state = FLUSH if br, STALL if lu (and not br), else RUN.
  - state_o reflects the action taken on the previous cycle.
  - Code 3 is illegal: it recovers to RUN on the next edge and sets hazard_error.
- Counters (registered, saturating at all-ones):
  - stall_count increments on each cycle with lu and not br.
  - flush_count increments on each cycle with br.
  - A simultaneous br and lu counts only in flush_count.
- Watchdog:
  - A 4-bit run counter increments on each cycle with lu and not br; any other cycle clears it to 0.
  - When the run counter reaches MAX_STALL-1 and lu holds again, hazard_error is set on that edge.
  - hazard_error is sticky until reset. With a correct ID/EX flush, a stall lasts exactly 1 cycle.
- Register reset values: state=RUN, stall_count=0, flush_count=0, run counter=0, hazard_error=0.
- Reset mid-stall or mid-flush: all registers clear on that edge and the controls follow the reset rule.
- Register $0 never causes a stall, even when idex_memread=1.

Decomposition:
- Package mips_hazard_pkg holds:
  - state typedef / localparams RUN, STALL, FLUSH;
  - REG_W=5 and REG_ZERO=5'd0;
  - DEFAULT_MAX_STALL=2.
- Sub-module sat_counter (parameter W; ports clock, reset, inc, count) is instantiated twice, for stall_count and flush_count.
- Detection and priority logic stay in hazard_ctrl.

Test Plan:
- Load-use: cycle N with idex_memread=1, idex_rt=8, ifid_rs=8 -> pc_write=0, ifid_write=0, idex_flush=1 in cycle N; state_o=1 and stall_count=1 after the edge. Cycle N+1 with idex_memread=0 -> pc_write=1, state_o=0.
- rt path and $0: idex_rt=9, ifid_rt=9, ifid_uses_rt=0 -> no stall. Same with ifid_uses_rt=1 -> stall. idex_rt=0, ifid_rs=0, idex_memread=1 -> no stall.
- Branch vs load-use in the same cycle: branch_taken=1 plus a matching lu -> pc_write=1 and all three flushes 1. After the edge: flush_count=1, stall_count unchanged, state_o=2.
- Watchdog: with MAX_STALL=2, hold a matching lu for 2 consecutive cycles -> hazard_error=1 after the 2nd edge. It remains 1 after lu drops, and clears only on reset.
- Saturation: with CNT_W=4, apply 20 stall cycles separated by idle cycles -> stall_count=15 and stays 15.
- Reset mid-operation: assert reset during a stall cycle -> flushes 1, pc_write=0 while reset is high. After the edge, counters=0, state_o=0, hazard_error=0.

Source files
------------

// File: rtl/mips_hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// The FSM state codes are visible on state_o.
package mips_hazard_pkg;

   localparam int REG_W = 5;
   localparam logic [REG_W-1:0] REG_ZERO = 5'd0;
   localparam int DEFAULT_MAX_STALL = 2;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      STALL = 2'd1,
      FLUSH = 2'd2
   } hz_state_e;

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
// Synchronous active-high reset.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         inc,
   output logic [W-1:0] count
);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (inc && (count_q != {W{1'b1}})) begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Load-use / taken-branch hazard controller driving PC and pipeline-register
// enables and flushes, with event counters and a stuck-stall watchdog.
//
//  state | meaning
//  RUN   | previous cycle advanced normally
//  STALL | previous cycle held PC and IF/ID for a load-use bubble
//  FLUSH | previous cycle squashed IF/ID, ID/EX, EX/MEM for a taken branch
//  (3)   | illegal; returns to RUN and raises hazard_error
module hazard_ctrl
   import mips_hazard_pkg::*;
#(
   parameter int CNT_W     = 16,
   parameter int MAX_STALL = DEFAULT_MAX_STALL
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [REG_W-1:0] ifid_rs,
   input  logic [REG_W-1:0] ifid_rt,
   input  logic             ifid_uses_rt,
   input  logic             idex_memread,
   input  logic [REG_W-1:0] idex_rt,
   input  logic             branch_taken,
   output logic             pc_write,
   output logic             ifid_write,
   output logic             ifid_flush,
   output logic             idex_flush,
   output logic             exmem_flush,
   output logic [CNT_W-1:0] stall_count,
   output logic [CNT_W-1:0] flush_count,
   output logic             hazard_error,
   output logic [1:0]       state_o
);

   localparam logic [3:0] RUN_LIMIT = 4'(MAX_STALL - 1);

   hz_state_e  state_q, state_d;
   logic [3:0] run_q, run_d;
   logic       err_q, err_d;

   logic lu;
   logic br;
   logic stall_evt;
   logic illegal_state;

   always_comb begin
      lu = idex_memread && (idex_rt != REG_ZERO) &&
           ((idex_rt == ifid_rs) || (ifid_uses_rt && (idex_rt == ifid_rt)));
      br = branch_taken;
      stall_evt = lu && !br;
   end

   // Controls are combinational so the pipeline registers act on this edge.
   always_comb begin
      pc_write    = 1'b1;
      ifid_write  = 1'b1;
      ifid_flush  = 1'b0;
      idex_flush  = 1'b0;
      exmem_flush = 1'b0;
      if (reset) begin
         pc_write    = 1'b0;
         ifid_write  = 1'b0;
         ifid_flush  = 1'b1;
         idex_flush  = 1'b1;
         exmem_flush = 1'b1;
      end else if (br) begin
         ifid_flush  = 1'b1;
         idex_flush  = 1'b1;
         exmem_flush = 1'b1;
      end else if (lu) begin
         pc_write    = 1'b0;
         ifid_write  = 1'b0;
         idex_flush  = 1'b1;
      end
   end

   always_comb begin
      state_d       = RUN;
      illegal_state = 1'b0;
      case (state_q)
         RUN, STALL, FLUSH: begin
            if (br) begin
               state_d = FLUSH;
            end else if (lu) begin
               state_d = STALL;
            end else begin
               state_d = RUN;
            end
         end
         default: begin
            state_d       = RUN;
            illegal_state = 1'b1;
         end
      endcase
   end

   // Watchdog: count back-to-back stall cycles; a correct bubble never repeats.
   always_comb begin
      run_d = 4'd0;
      if (stall_evt) begin
         run_d = (run_q == 4'hF) ? run_q : run_q + 4'd1;
      end
      err_d = err_q || illegal_state || (stall_evt && (run_q == RUN_LIMIT));
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= RUN;
         run_q   <= 4'd0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         run_q   <= run_d;
         err_q   <= err_d;
      end
   end

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clock (clock),
      .reset (reset),
      .inc   (stall_evt),
      .count (stall_count)
   );

   sat_counter #(.W(CNT_W)) u_flush_cnt (
      .clock (clock),
      .reset (reset),
      .inc   (br),
      .count (flush_count)
   );

   assign hazard_error = err_q;
   assign state_o      = state_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with narrow counters to reach saturation.
module tb_hazard_ctrl;

   localparam int CNT_W = 4;

   logic             clock = 1'b0;
   logic             reset;
   logic [4:0]       ifid_rs, ifid_rt, idex_rt;
   logic             ifid_uses_rt, idex_memread, branch_taken;
   logic             pc_write, ifid_write, ifid_flush, idex_flush, exmem_flush;
   logic [CNT_W-1:0] stall_count, flush_count;
   logic             hazard_error;
   logic [1:0]       state_o;

   int checks = 0;
   int failures = 0;

   hazard_ctrl #(.CNT_W(CNT_W), .MAX_STALL(2)) dut (
      .clock        (clock),
      .reset        (reset),
      .ifid_rs      (ifid_rs),
      .ifid_rt      (ifid_rt),
      .ifid_uses_rt (ifid_uses_rt),
      .idex_memread (idex_memread),
      .idex_rt      (idex_rt),
      .branch_taken (branch_taken),
      .pc_write     (pc_write),
      .ifid_write   (ifid_write),
      .ifid_flush   (ifid_flush),
      .idex_flush   (idex_flush),
      .exmem_flush  (exmem_flush),
      .stall_count  (stall_count),
      .flush_count  (flush_count),
      .hazard_error (hazard_error),
      .state_o      (state_o)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic cycle();
      @(posedge clock);
      #1;
   endtask

   task automatic drive(input logic mr, input logic [4:0] xrt, input logic [4:0] rs,
                        input logic [4:0] rt, input logic urt, input logic bt);
      idex_memread = mr;
      idex_rt      = xrt;
      ifid_rs      = rs;
      ifid_rt      = rt;
      ifid_uses_rt = urt;
      branch_taken = bt;
      #1;
   endtask

   // ctl packs {pc_write, ifid_write, ifid_flush, idex_flush, exmem_flush}
   function automatic logic [4:0] ctl();
      return {pc_write, ifid_write, ifid_flush, idex_flush, exmem_flush};
   endfunction

   initial begin
      reset = 1'b1;
      drive(1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b0);
      chk("reset_ctl", 32'(ctl()), 32'b00111);
      cycle();
      cycle();
      reset = 1'b0;
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
      chk("rst_state", 32'(state_o), 32'd0);
      chk("rst_stall", 32'(stall_count), 32'd0);
      chk("rst_flush", 32'(flush_count), 32'd0);
      chk("rst_err", 32'(hazard_error), 32'd0);
      chk("idle_ctl", 32'(ctl()), 32'b11000);

      // load-use on rs
      drive(1'b1, 5'd8, 5'd8, 5'd3, 1'b0, 1'b0);
      chk("lu_rs_ctl", 32'(ctl()), 32'b00010);
      cycle();
      chk("lu_rs_state", 32'(state_o), 32'd1);
      chk("lu_rs_cnt", 32'(stall_count), 32'd1);
      drive(1'b0, 5'd8, 5'd8, 5'd3, 1'b0, 1'b0);
      chk("lu_rel_ctl", 32'(ctl()), 32'b11000);
      cycle();
      chk("lu_rel_state", 32'(state_o), 32'd0);

      // rt path gated by ifid_uses_rt
      drive(1'b1, 5'd9, 5'd1, 5'd9, 1'b0, 1'b0);
      chk("rt_nouse_ctl", 32'(ctl()), 32'b11000);
      cycle();
      chk("rt_nouse_state", 32'(state_o), 32'd0);
      drive(1'b1, 5'd9, 5'd1, 5'd9, 1'b1, 1'b0);
      chk("rt_use_ctl", 32'(ctl()), 32'b00010);
      cycle();
      chk("rt_use_state", 32'(state_o), 32'd1);
      chk("rt_use_cnt", 32'(stall_count), 32'd2);
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
      cycle();

      // register $0 never stalls
      drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
      chk("r0_ctl", 32'(ctl()), 32'b11000);
      cycle();
      chk("r0_cnt", 32'(stall_count), 32'd2);
      chk("r0_state", 32'(state_o), 32'd0);

      // branch beats load-use
      drive(1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b1);
      chk("br_lu_ctl", 32'(ctl()), 32'b11111);
      cycle();
      chk("br_flush_cnt", 32'(flush_count), 32'd1);
      chk("br_stall_cnt", 32'(stall_count), 32'd2);
      chk("br_state", 32'(state_o), 32'd2);
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
      cycle();
      chk("br_after_state", 32'(state_o), 32'd0);
      chk("br_after_err", 32'(hazard_error), 32'd0);

      // 20 isolated stalls saturate the 4-bit counter
      for (int i = 0; i < 20; i++) begin
         drive(1'b1, 5'd7, 5'd7, 5'd0, 1'b0, 1'b0);
         cycle();
         drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
         cycle();
         if (i == 10) chk("sat_mid", 32'(stall_count), 32'd13);
      end
      chk("sat_cnt", 32'(stall_count), 32'd15);
      chk("sat_err", 32'(hazard_error), 32'd0);
      chk("sat_flush_cnt", 32'(flush_count), 32'd1);

      // watchdog: two back-to-back stall cycles
      drive(1'b1, 5'd4, 5'd4, 5'd0, 1'b0, 1'b0);
      cycle();
      chk("wd_first", 32'(hazard_error), 32'd0);
      cycle();
      chk("wd_second", 32'(hazard_error), 32'd1);
      chk("wd_cnt_sat", 32'(stall_count), 32'd15);
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
      cycle();
      cycle();
      chk("wd_sticky", 32'(hazard_error), 32'd1);

      // reset during a stall cycle
      drive(1'b1, 5'd4, 5'd4, 5'd0, 1'b0, 1'b0);
      chk("pre_rst_ctl", 32'(ctl()), 32'b00010);
      reset = 1'b1;
      #1;
      chk("mid_rst_ctl", 32'(ctl()), 32'b00111);
      cycle();
      chk("mid_rst_stall", 32'(stall_count), 32'd0);
      chk("mid_rst_flush", 32'(flush_count), 32'd0);
      chk("mid_rst_state", 32'(state_o), 32'd0);
      chk("mid_rst_err", 32'(hazard_error), 32'd0);
      reset = 1'b0;
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
      cycle();
      chk("post_rst_state", 32'(state_o), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
